// File: rtl/cmp_slice_seq.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices MSB-first through one narrow
// comparator. Optional macro CMP_SEQ_EARLY_EXIT_EN finishes on the first differing slice.
module cmp_slice_seq #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         signed_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic         lt_o,
  output logic         eq_o,
  output logic [N-1:0] res_o
);

  localparam int NSLICE = N / CHUNK;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_cfg
    $error("cmp_slice_seq: CHUNK must divide N");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            dec_q, dec_d;
  logic            lt_q, lt_d;
  logic [N-1:0]    bias;
  logic [CHUNK-1:0] sa, sb;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    bias        = '0;
    bias[N-1]   = signed_i;
  end

  assign sa = a_q[idx_q*CHUNK +: CHUNK];
  assign sb = b_q[idx_q*CHUNK +: CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    lt_d    = lt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          a_d     = a_i ^ bias;
          b_d     = b_i ^ bias;
          idx_d   = IW'(NSLICE - 1);
          dec_d   = 1'b0;
          lt_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (idx_q == '0) state_d = S_DONE;
        else             idx_d   = idx_q - 1'b1;
        // Only the most significant differing slice decides the ordering.
        if (!dec_q && sa != sb) begin
          dec_d = 1'b1;
          lt_d  = (sa < sb);
`ifdef CMP_SEQ_EARLY_EXIT_EN
          state_d = S_DONE;
`else
          state_d = state_d;
`endif
        end
      end
      S_DONE: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      lt_q    <= lt_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign res_valid_o = (state_q == S_DONE);
  assign lt_o        = res_valid_o & lt_q;
  assign eq_o        = res_valid_o & ~dec_q;

  always_comb begin
    res_o    = '0;
    res_o[0] = lt_o;
  end

endmodule
